// File: rtl/lane_seq_pkg.sv
// Shared definitions for the lane stream sequencer.
//   - seq_state_e : sequencer FSM states
//   - NLANES_DEF / LW_DEF : default lane count and lane width
//   - lane_slice  : extract lane idx from a packed lane bus
package lane_seq_pkg;

    localparam int unsigned NLANES_DEF = 8;
    localparam int unsigned LW_DEF     = 6;

    // Widest bus / lane lane_slice can handle; callers zero-extend into these.
    localparam int unsigned SLICE_BUS_W = 1024;
    localparam int unsigned SLICE_LW_W  = 64;

    typedef enum logic [0:0] {
        StIdle,
        StEmit
    } seq_state_e;

    // Returns bits [idx*lw +: lw] of bus, zero-extended to SLICE_LW_W.
    function automatic logic [SLICE_LW_W-1:0] lane_slice(
        input logic [SLICE_BUS_W-1:0] bus,
        input int unsigned            idx,
        input int unsigned            lw = LW_DEF
    );
        logic [SLICE_BUS_W-1:0] shifted;
        logic [SLICE_LW_W-1:0]  keep;
        shifted = bus >> (idx * lw);
        keep    = (lw >= SLICE_LW_W) ? '1 : ((SLICE_LW_W'(1) << lw) - SLICE_LW_W'(1));
        return shifted[SLICE_LW_W-1:0] & keep;
    endfunction

endpackage

// File: rtl/lane_stream_sequencer_if.sv
// Single-lane output stream of the lane sequencer.
//   out_valid/out_ready : handshake
//   out_data            : current lane value
//   out_idx             : index of the current lane
//   out_last            : current lane is the final enabled lane
// master = sequencer side, slave = consumer side.
interface lane_stream_sequencer_if
    import lane_seq_pkg::*;
#(
    parameter int unsigned NLANES = NLANES_DEF,
    parameter int unsigned LW     = LW_DEF
);
    localparam int unsigned IW = $clog2(NLANES);

    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] out_data;
    logic [IW-1:0] out_idx;
    logic          out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_idx,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_idx,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/lane_next_finder.sv
// Combinational search for the next enabled lane.
//   mask      : lane enables
//   cur_idx   : current lane (ignored when first=1)
//   msb_first : 1 searches downward, 0 upward
//   first     : 1 includes every lane, 0 only lanes strictly beyond cur_idx
//   found     : an eligible lane exists
//   next_idx  : nearest eligible lane in the search direction
//   has_more  : another enabled lane lies beyond next_idx
module lane_next_finder #(
    parameter int unsigned NLANES = 8,
    parameter int unsigned IW     = $clog2(NLANES)
) (
    input  logic [NLANES-1:0] mask,
    input  logic [IW-1:0]     cur_idx,
    input  logic              msb_first,
    input  logic              first,
    output logic              found,
    output logic [IW-1:0]     next_idx,
    output logic              has_more
);

    logic [NLANES-1:0] elig;

    always_comb begin
        elig = '0;
        for (int i = 0; i < int'(NLANES); i++) begin
            elig[i] = mask[i] &&
                      (first || (msb_first ? (IW'(i) < cur_idx) : (IW'(i) > cur_idx)));
        end

        found = |elig;

        // Last assignment wins: upward scan keeps the highest, downward scan the lowest.
        next_idx = '0;
        if (msb_first) begin
            for (int i = 0; i < int'(NLANES); i++) begin
                if (elig[i]) next_idx = IW'(i);
            end
        end else begin
            for (int i = int'(NLANES) - 1; i >= 0; i--) begin
                if (elig[i]) next_idx = IW'(i);
            end
        end

        has_more = 1'b0;
        for (int i = 0; i < int'(NLANES); i++) begin
            if (elig[i] && (msb_first ? (IW'(i) < next_idx) : (IW'(i) > next_idx))) begin
                has_more = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lane_stream_sequencer.sv
// Streams the enabled lanes of a packed lane bus out one lane per transfer.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a sequence (taken only while idle)
//   lanes_in   : packed lanes, lane i = [i*LW +: LW], captured on start
//   mask       : lane enables, captured on start
//   msb_first  : 1 = descending order, 0 = ascending, captured on start
//   abort      : cancel the running sequence (no done)
//   idle       : ready for start
//   done       : one-cycle pulse after the final transfer or an empty-mask start
//   stream     : valid/ready output stream (data, idx, last)
module lane_stream_sequencer
    import lane_seq_pkg::*;
#(
    parameter int unsigned NLANES = NLANES_DEF,
    parameter int unsigned LW     = LW_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [NLANES*LW-1:0]   lanes_in,
    input  logic [NLANES-1:0]      mask,
    input  logic                   msb_first,
    input  logic                   abort,
    output logic                   idle,
    output logic                   done,
    lane_stream_sequencer_if.master stream
);

    localparam int unsigned IW = $clog2(NLANES);

    seq_state_e           state_q;
    logic [NLANES*LW-1:0] lanes_q;
    logic [NLANES-1:0]    mask_q;
    logic                 dir_q;
    logic                 idle_q;
    logic                 valid_q;
    logic [LW-1:0]        data_q;
    logic [IW-1:0]        idx_q;
    logic                 last_q;
    logic                 done_q;

    // One finder serves both the start search (live inputs) and the
    // advance search (captured copy).
    logic              in_idle;
    logic [NLANES-1:0] f_mask;
    logic              f_dir;
    logic              f_found;
    logic [IW-1:0]     f_next;
    logic              f_more;

    assign in_idle = (state_q == StIdle);
    assign f_mask  = in_idle ? mask : mask_q;
    assign f_dir   = in_idle ? msb_first : dir_q;

    lane_next_finder #(
        .NLANES (NLANES),
        .IW     (IW)
    ) u_finder (
        .mask      (f_mask),
        .cur_idx   (idx_q),
        .msb_first (f_dir),
        .first     (in_idle),
        .found     (f_found),
        .next_idx  (f_next),
        .has_more  (f_more)
    );

    logic [LW-1:0] start_lane;
    logic [LW-1:0] next_lane;

    assign start_lane = LW'(lane_slice(SLICE_BUS_W'(lanes_in), 32'(f_next), LW));
    assign next_lane  = LW'(lane_slice(SLICE_BUS_W'(lanes_q), 32'(f_next), LW));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            lanes_q <= '0;
            mask_q  <= '0;
            dir_q   <= 1'b0;
            idle_q  <= 1'b1;
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // abort outranks start even while idle.
                    if (start && !abort) begin
                        if (f_found) begin
                            lanes_q <= lanes_in;
                            mask_q  <= mask;
                            dir_q   <= msb_first;
                            idx_q   <= f_next;
                            data_q  <= start_lane;
                            last_q  <= !f_more;
                            valid_q <= 1'b1;
                            idle_q  <= 1'b0;
                            state_q <= StEmit;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                StEmit: begin
                    if (abort) begin
                        valid_q <= 1'b0;
                        idle_q  <= 1'b1;
                        state_q <= StIdle;
                    end else if (valid_q && stream.out_ready) begin
                        if (last_q) begin
                            valid_q <= 1'b0;
                            idle_q  <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            idx_q  <= f_next;
                            data_q <= next_lane;
                            last_q <= !f_more;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign idle             = idle_q;
    assign done             = done_q;
    assign stream.out_valid = valid_q;
    assign stream.out_data  = data_q;
    assign stream.out_idx   = idx_q;
    assign stream.out_last  = last_q;

endmodule

// File: tb/tb_lane_stream_sequencer.sv
module tb_lane_stream_sequencer;

    localparam int unsigned NL = 8;
    localparam int unsigned LW = 6;
    localparam int unsigned IW = 3;

    typedef struct packed {
        logic [LW-1:0] data;
        logic [IW-1:0] idx;
        logic          last;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [NL*LW-1:0] lanes_in;
    logic [NL-1:0]  mask;
    logic           msb_first;
    logic           abort;
    logic           idle;
    logic           done;

    lane_stream_sequencer_if #(.NLANES(NL), .LW(LW)) s_if ();

    lane_stream_sequencer #(
        .NLANES (NL),
        .LW     (LW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .lanes_in  (lanes_in),
        .mask      (mask),
        .msb_first (msb_first),
        .abort     (abort),
        .idle      (idle),
        .done      (done),
        .stream    (s_if)
    );

    always #5 clk = ~clk;

    beat_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    transfers   = 0;
    logic  hold_pending = 1'b0;
    beat_t held;

    function automatic logic [NL*LW-1:0] ramp();
        logic [NL*LW-1:0] r;
        r = '0;
        for (int i = 0; i < int'(NL); i++) r[i*LW +: LW] = LW'(i);
        return r;
    endfunction

    // Scoreboard monitor: a transfer is valid && ready && !abort just before the edge.
    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        cur.data = s_if.out_data;
        cur.idx  = s_if.out_idx;
        cur.last = s_if.out_last;
        if (rst_n === 1'b1) begin
            if (hold_pending && s_if.out_valid === 1'b1) begin
                vectors++;
                if (cur !== held) begin
                    miscompares++;
                    $display("FAIL hold_stable: got %h want %h", cur, held);
                end
            end
            hold_pending = (s_if.out_valid === 1'b1) && (s_if.out_ready === 1'b0);
            held         = cur;
            if (s_if.out_valid === 1'b1 && s_if.out_ready === 1'b1 && abort === 1'b0) begin
                transfers++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_transfer: got %h want none", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        miscompares++;
                        $display("FAIL transfer: got data=%0d idx=%0d last=%0b want data=%0d idx=%0d last=%0b",
                                 cur.data, cur.idx, cur.last, e.data, e.idx, e.last);
                    end
                end
            end
        end else begin
            hold_pending = 1'b0;
        end
    end

    task automatic push_expected(input logic [NL*LW-1:0] l, input logic [NL-1:0] m,
                                 input logic dir);
        int    order[$];
        beat_t b;
        if (dir) begin
            for (int i = int'(NL) - 1; i >= 0; i--) if (m[i]) order.push_back(i);
        end else begin
            for (int i = 0; i < int'(NL); i++) if (m[i]) order.push_back(i);
        end
        for (int k = 0; k < order.size(); k++) begin
            b.data = l[order[k]*LW +: LW];
            b.idx  = IW'(order[k]);
            b.last = (k == order.size() - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic start_seq(input logic [NL*LW-1:0] l, input logic [NL-1:0] m, input logic dir);
        lanes_in  = l;
        mask      = m;
        msb_first = dir;
        push_expected(l, m, dir);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts negedges after start until done; n = lanes + 1 at full throughput.
    task automatic wait_done(input int budget, output int n);
        logic seen;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL done_timeout: got no done after %0d cycles want done", n);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL lanes_left: got %0d pending want 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mask = '0; msb_first = 1'b0;
        lanes_in = '0; s_if.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({idle, s_if.out_valid, s_if.out_data, s_if.out_idx, s_if.out_last, done}
            !== {1'b1, 1'b0, 6'd0, 3'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_values: got idle=%b v=%b d=%0d i=%0d l=%b done=%b want 1 0 0 0 0 0",
                     idle, s_if.out_valid, s_if.out_data, s_if.out_idx, s_if.out_last, done);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_full_desc();
        int n;
        s_if.out_ready = 1'b1;
        start_seq(ramp(), 8'hFF, 1'b1);
        vectors++;
        if (s_if.out_valid !== 1'b1 || idle !== 1'b0) begin
            miscompares++;
            $display("FAIL start_latency: got valid=%b idle=%b want 1 0", s_if.out_valid, idle);
        end
        wait_done(40, n);
        vectors++;
        if (n != 9) begin
            miscompares++;
            $display("FAIL full_throughput: got %0d cycles want 9", n);
        end
        vectors++;
        if (idle !== 1'b1 || s_if.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL end_state: got idle=%b valid=%b want 1 0", idle, s_if.out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sparse();
        int n;
        for (int d = 0; d < 2; d++) begin
            s_if.out_ready = 1'b1;
            start_seq(ramp(), 8'b1010_0100, d[0]);
            wait_done(40, n);
            vectors++;
            if (n != 4) begin
                miscompares++;
                $display("FAIL sparse_cycles: got %0d want 4 (dir %0d)", n, d);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int   cyc;
        int   t0;
        logic seen;
        t0   = transfers;
        seen = 1'b0;
        cyc  = 0;
        s_if.out_ready = 1'b1;
        start_seq(ramp(), 8'hFF, 1'b1);
        while (!seen && cyc < 200) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
            cyc++;
            s_if.out_ready = (cyc % 3 == 0);
        end
        s_if.out_ready = 1'b1;
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL bp_done: got no done want done");
        end
        vectors++;
        if (transfers - t0 != 8 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL bp_count: got %0d transfers %0d pending want 8 0",
                     transfers - t0, exp_q.size());
        end
    endtask

    task automatic test_empty_mask();
        int n;
        s_if.out_ready = 1'b1;
        lanes_in = ramp(); mask = '0; msb_first = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b1 || idle !== 1'b1 || s_if.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_mask: got done=%b idle=%b valid=%b want 1 1 0",
                     done, idle, s_if.out_valid);
        end
        mask = 8'h81;
        push_expected(ramp(), 8'h81, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        vectors++;
        if (s_if.out_valid !== 1'b1 || idle !== 1'b0 || s_if.out_idx !== 3'd0) begin
            miscompares++;
            $display("FAIL restart_after_done: got valid=%b idle=%b idx=%0d want 1 0 0",
                     s_if.out_valid, idle, s_if.out_idx);
        end
        wait_done(40, n);
        vectors++;
        if (n != 3) begin
            miscompares++;
            $display("FAIL restart_cycles: got %0d want 3", n);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        logic  hit;
        beat_t b;
        int    dones;
        s_if.out_ready = 1'b1;
        lanes_in = ramp(); mask = 8'hFF; msb_first = 1'b1;
        for (int i = 7; i >= 5; i--) begin
            b.data = LW'(i); b.idx = IW'(i); b.last = 1'b0;
            exp_q.push_back(b);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            if (s_if.out_valid === 1'b1 && s_if.out_idx === 3'd4) begin
                hit = 1'b1;
            end else begin
                // Ignored in EMIT: start, new lanes, new mask.
                start = 1'b1; lanes_in = ~ramp(); mask = 8'h0F;
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        vectors++;
        if (!hit || s_if.out_data !== 6'd4) begin
            miscompares++;
            $display("FAIL abort_reach_lane4: got hit=%b data=%0d want 1 4", hit, s_if.out_data);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        vectors++;
        if (s_if.out_valid !== 1'b0 || idle !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_state: got valid=%b idle=%b done=%b want 0 1 0",
                     s_if.out_valid, idle, done);
        end
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        vectors++;
        if (dones != 0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL abort_after: got %0d dones %0d pending want 0 0", dones, exp_q.size());
        end
        lanes_in = ramp();
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic  hit;
        beat_t b;
        int    dones;
        int    n;
        s_if.out_ready = 1'b1;
        lanes_in = ramp(); mask = 8'hFF; msb_first = 1'b1;
        for (int i = 7; i >= 4; i--) begin
            b.data = LW'(i); b.idx = IW'(i); b.last = 1'b0;
            exp_q.push_back(b);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            if (s_if.out_valid === 1'b1 && s_if.out_idx === 3'd3) hit = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (!hit || {idle, s_if.out_valid, s_if.out_data, s_if.out_idx, s_if.out_last, done}
                    !== {1'b1, 1'b0, 6'd0, 3'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset: got hit=%b idle=%b v=%b d=%0d i=%0d l=%b done=%b want 1 1 0 0 0 0 0",
                     hit, idle, s_if.out_valid, s_if.out_data, s_if.out_idx, s_if.out_last, done);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL reset_pending: got %0d want 0", exp_q.size());
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        vectors++;
        if (dones != 0) begin
            miscompares++;
            $display("FAIL reset_no_done: got %0d want 0", dones);
        end
        @(posedge clk); #1;
        start_seq(ramp(), 8'h01, 1'b1);
        wait_done(40, n);
        vectors++;
        if (n != 2) begin
            miscompares++;
            $display("FAIL single_lane: got %0d cycles want 2", n);
        end
    endtask

    initial begin
        test_reset();
        test_full_desc();
        test_sparse();
        test_backpressure();
        test_empty_mask();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/lane_stream_sequencer.md
Name: lane_stream_sequencer

Overview:
- Sequences a packed array of NLANES fixed-width lanes onto a single-lane output stream with a valid/ready handshake.
- The array is the kind built by a generate loop of constant-value sub-blocks, and the output is one lane per transfer.
- Order matches the streaming-concatenation convention: the highest lane goes first when msb_first=1, lane 0 goes first otherwise.
- Disabled lanes are skipped per a mask. It sits between the packed lane bus and any narrow serial consumer.

Parameters:
- NLANES, 8, number of lanes (power of two, >=2)
- LW, 6, width of each lane in bits
- IW, $clog2(NLANES), width of lane index (derived; not overridable)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a sequence; accepted only when idle=1
- lanes_in  input  NLANES*LW  packed lanes; lane i = bits [i*LW +: LW]; sampled on accepted start
- mask  input  NLANES  lane enables; sampled on accepted start
- msb_first  input  1  1: descending lane order, 0: ascending; sampled on accepted start
- abort  input  1  cancel the sequence in progress
- idle  output  1  ready to accept start
- out_valid  output  1  out_data/out_idx/out_last are valid
- out_ready  input  1  consumer accepts the current lane
- out_data  output  LW  current lane value
- out_idx  output  IW  index of the current lane
- out_last  output  1  current lane is the final enabled lane
- done  output  1  one-cycle pulse after the final handshake, or after an empty-mask start

Behaviour:
- Reset values: idle=1, out_valid=0, out_data=0, out_idx=0, out_last=0, done=0. All outputs are registered.
- States are IDLE and EMIT.
- IDLE, start=1, mask!=0:
  - Capture lanes_in, mask and msb_first.
  - Select the first enabled lane: the highest set mask bit if msb_first=1, the lowest if 0.
  - Go to EMIT. out_valid=1 on the next cycle (latency 1) and idle=0.
- IDLE, start=1, mask==0: stay in IDLE, out_valid stays 0, done=1 on the next cycle.
- EMIT, out_valid=1 and out_ready=0: out_data, out_idx and out_last are held stable.
- EMIT, handshake (out_valid && out_ready):
  - out_last=0: advance to the next enabled lane strictly beyond the current index in the captured direction. The new lane is presented the next cycle with out_valid continuously 1 (one lane per cycle at full throughput).
  - out_last=1: go to IDLE. Next cycle out_valid=0, idle=1, done=1.
- out_last=1 exactly when no enabled lane remains beyond out_idx in the current direction.
- Lane indices never wrap; a sequence visits each enabled lane exactly once.
- abort=1 in EMIT (highest priority, including over a same-cycle handshake): go to IDLE next cycle with out_valid=0, idle=1 and no done pulse.
- abort=1 in IDLE has no effect, and abort beats start in the same cycle.
- start while in EMIT is ignored. The captured copy is used throughout, so changes to lanes_in or mask after capture have no effect.
- done and start in the same cycle: start is accepted if idle=1.
- Asynchronous reset mid-sequence returns immediately to the reset values. No done is produced for the interrupted sequence.

Decomposition:
- Shared package lane_seq_pkg holds:
  - the state enum (IDLE, EMIT)
  - localparam defaults NLANES_DEF=8, LW_DEF=6
  - a function lane_slice(bus, idx) returning bits [idx*LW +: LW]
- Sub-module lane_next_finder (purely combinational):
  - inputs: mask, current index, direction, a first flag (search including vs. strictly beyond)
  - outputs: found, next_idx, and has_more (another enabled lane exists after next_idx)
  - the main block uses it both at start and on each handshake, registering out_last from has_more.

Test Plan:
- Lane i = i, mask=8'hFF, msb_first=1, out_ready=1: out_data sequence 7,6,5,4,3,2,1,0 on 8 consecutive cycles, out_last only on 0, done one cycle after.
- Lane i = i, mask=8'b1010_0100, msb_first=0, out_ready=1: sequence 2,5,7 with out_idx 2,5,7, out_last on 7; then msb_first=1 gives 7,5,2.
- Lane i = i, mask=8'hFF, out_ready toggled 1,0,0,1,...: each lane held stable while ready=0, no lane lost or duplicated, 8 transfers total.
- start with mask=0: no out_valid, done=1 on the next cycle, idle stays 1; a second start the following cycle is accepted.
- abort with out_ready=1 while lane 4 is presented (mask=8'hFF, msb_first=1): lane 4 not counted, out_valid=0 next cycle, no done; start or lanes_in changes during EMIT do not alter the sequence.
- rst_n low while lane 3 is presented: outputs at reset values immediately; after release, a fresh start with mask=8'h01 emits lane 0 only with out_last=1.
